// File: rtl/outch_ctrl_pkg.sv
// Shared definitions for the output-channel controller: port count, flit
// type encodings, enable constants, FSM state type and a port-index helper.
package outch_ctrl_pkg;

  localparam int NPORT = 5;
  localparam int PORTW = 3;
  localparam int VCH   = 1;
  localparam int VCHW  = 1;

  localparam logic [1:0] TYPE_HEAD     = 2'b00;
  localparam logic [1:0] TYPE_DATA     = 2'b01;
  localparam logic [1:0] TYPE_TAIL     = 2'b10;
  localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Next port index, wrapping after the last input port.
  function automatic logic [PORTW-1:0] next_port(input logic [PORTW-1:0] p);
    return (p == PORTW'(NPORT - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/outch_ctrl_rr_arb5.sv
// Five-input round-robin arbiter. Purely combinational: searches elig
// upward from ptr (mod 5) and returns a one-hot winner and its index.
module rr_arb5
  import outch_ctrl_pkg::*;
(
  input  logic [NPORT-1:0] elig,
  input  logic [PORTW-1:0] ptr,
  output logic [NPORT-1:0] win,
  output logic [PORTW-1:0] idx,
  output logic             found
);

  // First eligible port at or after the pointer wins.
  always_comb begin
    logic [PORTW-1:0] p;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    p     = ptr;
    for (int k = 0; k < NPORT; k++) begin
      if (!found && elig[p]) begin
        found  = 1'b1;
        idx    = p;
        win[p] = 1'b1;
      end
      p = next_port(p);
    end
  end

endmodule

// File: rtl/outch_ctrl.sv
// Output-channel controller: wormhole switch grant for five input ports,
// downstream per-VC credit counters and per-VC packet locks.
// Optional build macro OUTCH_ERR_CHK_EN adds a sticky err[2:0] output
// (bit0 credit overflow, bit1 send at zero credits, bit2 ungranted send).
//
// Handshake: a port raises req with its target VC; once grt[i] is high it
// may assert send[i] for one flit per cycle, with last[i] on the tail.
// Flits are only honoured from the granted port; the grant drops on the
// edge that accepts the tail, leaving at least one idle grant cycle.
module outch_ctrl
  import outch_ctrl_pkg::*;
#(
  parameter int PCHID   = 0,
  parameter int NVCH    = 2,
  parameter int CREDITS = 4,
  localparam int VW = (NVCH > 1) ? $clog2(NVCH) : 1,
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT*VW-1:0] req_vc,
  input  logic [NPORT-1:0]    send,
  input  logic [NPORT-1:0]    last,
  input  logic                credit_in,
  input  logic [VW-1:0]       credit_vc,
  output logic [NPORT-1:0]    grt,
  output logic [NVCH-1:0]     irdy,
  output logic [NVCH-1:0]     ilck,
  output logic                osend,
  output logic [VW-1:0]       ovc
`ifdef OUTCH_ERR_CHK_EN
  ,
  output logic [2:0]          err
`endif
);

  state_t           state, state_nx;
  logic [PORTW-1:0] owner, owner_nx;
  logic [PORTW-1:0] ptr, ptr_nx;
  logic [NPORT-1:0] grt_nx;
  logic             sent, sent_nx;
  logic [NVCH-1:0]  lock;
  logic [CW-1:0]    cnt [NVCH];

  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] win;
  logic [PORTW-1:0] win_idx;
  logic             win_found;
  logic             gsend;
  logic             gtail;
  logic [NVCH-1:0]  dec_v;
  logic [NVCH-1:0]  inc_v;

  assign ovc   = req_vc[int'(owner)*VW +: VW];
  assign osend = |(send & grt);
  assign gsend = send[owner] & grt[owner];
  assign gtail = gsend & last[owner];
  assign ilck  = lock;

  // A request is eligible only if its target VC is not owned by a packet.
  always_comb begin
    logic [VW-1:0] vc;
    logic          locked;
    elig = '0;
    for (int i = 0; i < NPORT; i++) begin
      vc     = req_vc[i*VW +: VW];
      locked = 1'b0;
      for (int v = 0; v < NVCH; v++) begin
        if (VW'(v) == vc) locked = lock[v];
      end
      elig[i] = req[i] & ~locked;
    end
  end

  rr_arb5 u_arb (
    .elig  (elig),
    .ptr   (ptr),
    .win   (win),
    .idx   (win_idx),
    .found (win_found)
  );

  // Grant FSM next-state: grant in IDLE, hold until tail or abort in BUSY.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    grt_nx   = grt;
    sent_nx  = sent;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          owner_nx = win_idx;
          grt_nx   = win;
          sent_nx  = 1'b0;
          state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (gtail) begin
          grt_nx   = '0;
          ptr_nx   = next_port(owner);
          sent_nx  = 1'b0;
          state_nx = ST_IDLE;
        end else if (!req[owner] && !send[owner] && !sent) begin
          // Requester withdrew before any flit left: release, keep pointer.
          grt_nx   = '0;
          state_nx = ST_IDLE;
        end else if (gsend) begin
          sent_nx = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Grant FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
      grt   <= '0;
      sent  <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      grt   <= grt_nx;
      sent  <= sent_nx;
    end
  end

  // Per-VC credit consume/return strobes.
  always_comb begin
    dec_v = '0;
    inc_v = '0;
    for (int v = 0; v < NVCH; v++) begin
      dec_v[v] = gsend && (ovc == VW'(v));
      inc_v[v] = credit_in && (credit_vc == VW'(v));
    end
  end

  // VC lock: head flit sets, tail clears; a HEADTAIL flit nets to unlocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock <= '0;
    end else begin
      for (int v = 0; v < NVCH; v++) begin
        if (dec_v[v]) begin
          if (gtail) lock[v] <= 1'b0;
          else       lock[v] <= 1'b1;
        end
      end
    end
  end

  // Credit counters saturate at both ends; send plus return cancels out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NVCH; v++) cnt[v] <= CW'(CREDITS);
    end else begin
      for (int v = 0; v < NVCH; v++) begin
        if (dec_v[v] && !inc_v[v] && cnt[v] != '0)
          cnt[v] <= cnt[v] - 1'b1;
        else if (inc_v[v] && !dec_v[v] && cnt[v] != CW'(CREDITS))
          cnt[v] <= cnt[v] + 1'b1;
      end
    end
  end

  // Downstream readiness straight from the counters.
  always_comb begin
    irdy = '0;
    for (int v = 0; v < NVCH; v++) irdy[v] = (cnt[v] != '0);
  end

`ifdef OUTCH_ERR_CHK_EN
  // Sticky protocol error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      for (int v = 0; v < NVCH; v++) begin
        if (inc_v[v] && !dec_v[v] && cnt[v] == CW'(CREDITS)) err[0] <= 1'b1;
        if (dec_v[v] && cnt[v] == '0)                        err[1] <= 1'b1;
      end
      if (|(send & ~grt)) err[2] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_outch_ctrl.sv
// Directed bench for outch_ctrl (NVCH=2, CREDITS=4).
module tb_outch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] req_vc;
  logic [4:0] send;
  logic [4:0] last;
  logic       credit_in;
  logic [0:0] credit_vc;
  logic [4:0] grt;
  logic [1:0] irdy;
  logic [1:0] ilck;
  logic       osend;
  logic [0:0] ovc;
`ifdef OUTCH_ERR_CHK_EN
  logic [2:0] err;
`endif

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];

  outch_ctrl #(.PCHID(0), .NVCH(2), .CREDITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_vc    (req_vc),
    .send      (send),
    .last      (last),
    .credit_in (credit_in),
    .credit_vc (credit_vc),
    .grt       (grt),
    .irdy      (irdy),
    .ilck      (ilck),
    .osend     (osend),
    .ovc       (ovc)
`ifdef OUTCH_ERR_CHK_EN
    ,
    .err       (err)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req       = '0;
    req_vc    = '0;
    send      = '0;
    last      = '0;
    credit_in = 1'b0;
    credit_vc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grt !== 5'b00000) begin errors++; $display("FAIL reset_grt: got=%b exp=%b", grt, 5'b00000); end
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL reset_irdy: got=%b exp=%b", irdy, 2'b11); end
    checks++; if (ilck !== 2'b00) begin errors++; $display("FAIL reset_ilck: got=%b exp=%b", ilck, 2'b00); end
    req = 5'b00001;
    step();
    send = 5'b00001;
    step();
    checks++; if (ilck !== 2'b01) begin errors++; $display("FAIL midpkt_ilck: got=%b exp=%b", ilck, 2'b01); end
    rst = 1'b1;
    #1;
    checks++; if (grt !== 5'b00000) begin errors++; $display("FAIL async_rst_grt: got=%b exp=%b", grt, 5'b00000); end
    checks++; if (irdy !== 2'b11) begin errors++; $display("FAIL async_rst_irdy: got=%b exp=%b", irdy, 2'b11); end
    checks++; if (ilck !== 2'b00) begin errors++; $display("FAIL async_rst_ilck: got=%b exp=%b", ilck, 2'b00); end
    checks++; if (dut.cnt[0] !== 3'd4) begin errors++; $display("FAIL async_rst_cnt0: got=%0d exp=4", dut.cnt[0]); end
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_grant_packet();
    do_reset();
    req = 5'b10100;
    step();
    checks++; if (grt !== 5'b00100) begin errors++; $display("FAIL grant_first: got=%b exp=%b", grt, 5'b00100); end
    send = 5'b00100;
    #1;
    checks++; if (osend !== 1'b1 || ovc !== 1'b0) begin errors++; $display("FAIL link_out: got=%b/%b exp=1/0", osend, ovc); end
    step();
    step();
    last = 5'b00100;
    step();
    checks++; if (grt !== 5'b00000) begin errors++; $display("FAIL tail_release: got=%b exp=%b", grt, 5'b00000); end
    checks++; if (dut.ptr !== 3'd3) begin errors++; $display("FAIL ptr_after_tail: got=%0d exp=3", dut.ptr); end
    checks++; if (dut.cnt[0] !== 3'd1 || ilck !== 2'b00) begin errors++; $display("FAIL pkt_cnt_lock: got=%0d/%b exp=1/00", dut.cnt[0], ilck); end
    req = 5'b10000; send = '0; last = '0;
    step();
    checks++; if (grt !== 5'b10000) begin errors++; $display("FAIL grant_next: got=%b exp=%b", grt, 5'b10000); end
    req = '0;
    step();
    checks++; if (grt !== 5'b00000 || dut.ptr !== 3'd3) begin errors++; $display("FAIL abort: got=%b ptr=%0d exp=00000 ptr=3", grt, dut.ptr); end
  endtask

  task automatic test_lock_mask();
    do_reset();
    req = 5'b00010; req_vc = 5'b00010;
    step();
    checks++; if (grt !== 5'b00010) begin errors++; $display("FAIL lock_grant1: got=%b exp=%b", grt, 5'b00010); end
    send = 5'b00010;
    step();
    send = '0; req = 5'b01010; req_vc = 5'b01010;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (grt !== 5'b00010 || ilck !== 2'b10) begin errors++; $display("FAIL lock_hold: got=%b/%b exp=00010/10", grt, ilck); end
    end
    send = 5'b00010; last = 5'b00010;
    step();
    checks++; if (grt !== 5'b00000 || ilck !== 2'b00 || dut.ptr !== 3'd2) begin errors++; $display("FAIL lock_tail: got=%b/%b ptr=%0d exp=00000/00 ptr=2", grt, ilck, dut.ptr); end
    send = '0; last = '0; req = 5'b01000;
    step();
    checks++; if (grt !== 5'b01000) begin errors++; $display("FAIL lock_grant3: got=%b exp=%b", grt, 5'b01000); end
    checks++; if (dut.cnt[1] !== 3'd2) begin errors++; $display("FAIL lock_cnt1: got=%0d exp=2", dut.cnt[1]); end
  endtask

  task automatic test_credits();
    do_reset();
    req = 5'b00001;
    step();
    send = 5'b00001;
    step(); step(); step();
    last = 5'b00001;
    step();
    checks++; if (irdy !== 2'b10 || dut.cnt[0] !== 3'd0) begin errors++; $display("FAIL credit_empty: got=%b cnt=%0d exp=10 cnt=0", irdy, dut.cnt[0]); end
    send = '0; last = '0;
    step();
    send = 5'b00001; last = 5'b00001;
    step();
    checks++; if (dut.cnt[0] !== 3'd0) begin errors++; $display("FAIL credit_underflow: got=%0d exp=0", dut.cnt[0]); end
    send = '0; last = '0; req = '0;
    credit_in = 1'b1; credit_vc = 1'b0;
    step(); step();
    credit_in = 1'b0;
    checks++; if (dut.cnt[0] !== 3'd2 || irdy !== 2'b11) begin errors++; $display("FAIL credit_return: got=%0d/%b exp=2/11", dut.cnt[0], irdy); end
    req = 5'b00001;
    step();
    send = 5'b00001; last = 5'b00001; credit_in = 1'b1;
    step();
    checks++; if (dut.cnt[0] !== 3'd2) begin errors++; $display("FAIL credit_same_cycle: got=%0d exp=2", dut.cnt[0]); end
    idle_inputs();
    credit_in = 1'b1; credit_vc = 1'b1;
    step();
    credit_in = 1'b0;
    checks++; if (dut.cnt[1] !== 3'd4) begin errors++; $display("FAIL credit_overflow: got=%0d exp=4", dut.cnt[1]); end
`ifdef OUTCH_ERR_CHK_EN
    checks++; if (err !== 3'b011) begin errors++; $display("FAIL err_ovf_udf: got=%b exp=%b", err, 3'b011); end
    step();
    checks++; if (err !== 3'b011) begin errors++; $display("FAIL err_sticky: got=%b exp=%b", err, 3'b011); end
`endif
  endtask

  task automatic test_headtail();
    do_reset();
    req = 5'b10000;
    step();
    checks++; if (grt !== 5'b10000) begin errors++; $display("FAIL ht_grant: got=%b exp=%b", grt, 5'b10000); end
    send = 5'b10000; last = 5'b10000;
    step();
    checks++; if (grt !== 5'b00000 || ilck !== 2'b00) begin errors++; $display("FAIL ht_release: got=%b/%b exp=00000/00", grt, ilck); end
    checks++; if (dut.cnt[0] !== 3'd3 || dut.ptr !== 3'd0) begin errors++; $display("FAIL ht_cnt_ptr: got=%0d/%0d exp=3/0", dut.cnt[0], dut.ptr); end
  endtask

  task automatic test_ignored_send();
    do_reset();
    req = 5'b00010; req_vc = 5'b00010;
    step();
    send = 5'b00001;
    #1;
    checks++; if (osend !== 1'b0) begin errors++; $display("FAIL ignored_osend: got=%b exp=0", osend); end
    step();
    checks++; if (dut.cnt[0] !== 3'd4 || dut.cnt[1] !== 3'd4 || ilck !== 2'b00 || grt !== 5'b00010) begin
      errors++; $display("FAIL ignored_state: cnt=%0d/%0d ilck=%b grt=%b exp=4/4 00 00010", dut.cnt[0], dut.cnt[1], ilck, grt);
    end
`ifdef OUTCH_ERR_CHK_EN
    checks++; if (err !== 3'b100) begin errors++; $display("FAIL err_ungranted: got=%b exp=%b", err, 3'b100); end
`endif
    send = '0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    do_reset();
    req = 5'b11111;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00100);
    while (exp_q.size() > 0) begin
      step();
      exp = exp_q.pop_front();
      checks++; if (grt !== exp) begin errors++; $display("FAIL b2b_grant: got=%b exp=%b", grt, exp); end
      send = exp; last = exp;
      step();
      checks++; if (grt !== 5'b00000) begin errors++; $display("FAIL b2b_gap: got=%b exp=%b", grt, 5'b00000); end
      send = '0; last = '0;
    end
    checks++; if (dut.cnt[0] !== 3'd1) begin errors++; $display("FAIL b2b_cnt0: got=%0d exp=1", dut.cnt[0]); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_grant_packet();
    test_lock_mask();
    test_credits();
    test_headtail();
    test_ignored_send();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/outch_ctrl.md
Name: outch_ctrl

Overview:
- Output-side controller for one physical output channel of the router. It is the responder to the per-input-VC request/send state machines.
- Arbitrates the five input-port requests and holds the switch grant for a whole packet (wormhole).
- Tracks downstream per-VC credits and per-VC packet locks, and drives the grt_x, irdy_x and ilck_x signals that the input VCs consume.
- One instance per output port; the instance's irdy/ilck vectors fan out to every input VC.

Parameters:
- PCHID, 0, physical output channel index (identification only).
- NVCH, 2, number of downstream virtual channels (VCH+1); VW = clog2(NVCH), minimum 1.
- CREDITS, 4, downstream buffer depth per VC in flits; counter width CW = clog2(CREDITS+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  5  req[i] = input port i requests this channel
- req_vc  in  5*VW  requested downstream VC of port i, in bits [i*VW +: VW]
- send  in  5  send[i] = port i drives a flit onto this channel this cycle
- last  in  5  last[i] = flit from port i is TAIL or HEADTAIL
- credit_in  in  1  downstream freed one buffer slot
- credit_vc  in  VW  VC that credit_in refers to
- grt  out  5  one-hot switch grant (grt_0..grt_4 at the instance boundary)
- irdy  out  NVCH  irdy[v] = downstream VC v has at least one credit
- ilck  out  NVCH  ilck[v] = VC v is owned by an in-flight packet
- osend  out  1  flit valid on the link
- ovc  out  VW  VC tag on the link

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - state=IDLE, grt=0, owner=0, rr pointer=0.
  - cnt[v]=CREDITS, so irdy is all ones.
  - lock=0, so ilck=0.
- FSM IDLE:
  - elig[i] = req[i] & ~lock[req_vc_i].
  - If any elig bit is set, the round-robin winner is searched from pointer upward, mod 5.
  - The winner is registered into owner, grt becomes one-hot(owner) on the next edge, and state goes to BUSY. Grant latency is 1 cycle from request.
  - If no elig bit is set, grt stays 0.
- FSM BUSY:
  - grt is held constant.
  - On send[owner] & last[owner]: grt clears at the next edge, pointer = owner+1 mod 5, state goes to IDLE. This forces at least one idle grant cycle between packets.
  - Abort: if req[owner]=0 and send[owner]=0 and no flit of this packet has been sent yet, release to IDLE with the pointer unchanged.
- Lock:
  - Set lock[v] at the edge where send[owner] occurs with v = req_vc_owner and lock[v]=0 (head flit).
  - Clear lock[v] on send[owner] & last[owner].
  - HEADTAIL sets and clears in the same cycle: the net result is lock=0.
- Credits:
  - cnt[v] decrements on a send to VC v and increments on credit_in with credit_vc=v.
  - Both in the same cycle for the same v: unchanged.
  - Increment at CREDITS: hold (overflow). Decrement at 0: hold (underflow).
- irdy[v] = (cnt[v] != 0), combinational from the register.
- osend = |(send & grt). ovc = req_vc of owner. Both combinational, no added latency.
- send[i] with grt[i]=0 is ignored for osend, lock and credits.
- Reset mid-packet clears all state immediately. The upstream VC is reset by the same rst.

Optional Feature:
- OUTCH_ERR_CHK_EN defined: adds output err[2:0], sticky until reset.
  - bit0 = credit overflow
  - bit1 = send while cnt=0
  - bit2 = send from a non-granted port
- Not defined: no err port and no checking logic. Hold behaviour is identical in both builds.

Decomposition:
- Shared defines header: NPORT=5, TYPE_HEAD/DATA/TAIL/HEADTAIL encodings, Enable/Disable, VCH/VCHW/PORTW.
- One sub-module, rr_arb5: 5-input round-robin arbiter taking elig and pointer and returning a one-hot winner plus its index. Purely combinational; owner and pointer registers stay in outch_ctrl.

Test Plan:
- Reset: rst=1 mid-run -> grt=0, irdy=2'b11, ilck=2'b00 in the same cycle, with no clock edge required.
- req=5'b10100, pointer=0, both VCs unlocked -> grt=5'b00100 one cycle later.
  - 3-flit packet (send[2] for 3 cycles, last on 3rd) -> grt=0 next cycle, then grt=5'b10000, pointer=3.
- Lock masking: port 1 owns VC1 mid-packet; port 3 requests VC1 -> port 3 not granted and ilck[1]=1 until port 1's tail.
  - Port 3 is then granted after the one idle cycle.
- Credits, CREDITS=4: 4 sends on VC0 with no credit_in -> cnt=0, irdy[0]=0.
  - Simultaneous send and credit_in on VC0 at cnt=2 -> cnt stays 2.
- HEADTAIL from port 4 on VC0 -> ilck[0] never asserts, grt released after 1 flit, cnt[0] decremented by 1.
- With OUTCH_ERR_CHK_EN: credit_in on VC1 at cnt=4 -> err[0]=1 and sticky, cnt stays 4; send[0] while grt=5'b00010 -> err[2]=1.
